ol_rx_link_monitor: RTL and testbench

- Receive-side counterpart of the optical-link controller; sits between the transceiver RX parallel output and the downstream data path.
- Locks onto the K-character alignment pattern, then verifies the incrementing-counter test sequence from the far-end transmitter.
- Once the sequence verifies, forwards payload words with a valid strobe and reports link status/errors.
- The mode encoding matches the transmit-side controller, so both ends can be compared directly.

---
 rtl/ol_rx_link_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_ol_rx_link_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ol_rx_link_monitor.sv
// Optical-link receive monitor: K-word alignment, counter test sequence, payload forwarding.
// Define OL_RX_ERR_SNAPSHOT_EN to add the first-mismatch snapshot outputs.
//
// state  | meaning
// HUNT   | counting consecutive aligned K-words toward lock
// LOCKED | aligned, waiting for first counter word of the test sequence
// TEST   | checking incrementing counter, timeout timer running
// DATA   | link verified, forwarding payload
// FAULT  | test timeout or loss of signal, held until LIVE=0

module ol_rx_link_monitor #(
   parameter logic [15:0] ALIGN_WORD     = 16'h50BC,
   parameter int          ALIGN_LOCK_CNT = 64,
   parameter int          TEST_PASS_CNT  = 2047,
   parameter int          TEST_TIMEOUT   = 65535,
   parameter int          LOS_CNT        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        LIVE,
   input  logic [15:0] rx_data,
   input  logic [1:0]  rx_datak,
   input  logic        rx_valid,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic        link_up,
   output logic        error,
   output logic [1:0]  mode,
   output logic [15:0] err_cnt
`ifdef OL_RX_ERR_SNAPSHOT_EN
   ,
   output logic [15:0] snap_expected,
   output logic [15:0] snap_received,
   output logic        snap_valid
`endif
);

   localparam logic [15:0] LOCK_TC  = 16'(ALIGN_LOCK_CNT);
   localparam logic [15:0] PASS_TC  = 16'(TEST_PASS_CNT);
   localparam logic [15:0] TMO_LOAD = 16'(TEST_TIMEOUT);
   localparam logic [15:0] LOS_TC   = 16'(LOS_CNT);

   typedef enum logic [2:0] {ST_HUNT, ST_LOCKED, ST_TEST, ST_DATA, ST_FAULT} state_t;

   state_t      state_q, state_d;
   logic [15:0] align_q, align_d, pass_q, pass_d, tmo_q, tmo_d, los_q, los_d;
   logic [15:0] exp_q, exp_d, err_q, err_d, data_out_q, data_out_d;
   logic        data_valid_q, data_valid_d, link_up_q, link_up_d, error_q, error_d;
   logic [1:0]  mode_q, mode_d;
   logic        aligned, word_ok;
`ifdef OL_RX_ERR_SNAPSHOT_EN
   logic [15:0] snap_exp_q, snap_exp_d, snap_rx_q, snap_rx_d;
   logic        snap_v_q, snap_v_d;
`endif

   always_comb begin
      aligned      = rx_valid && (rx_datak == 2'b11) && (rx_data == ALIGN_WORD);
      word_ok      = (rx_datak == 2'b00) && (rx_data == exp_q);
      state_d      = state_q;
      align_d      = align_q;
      pass_d       = pass_q;
      tmo_d        = tmo_q;
      los_d        = los_q;
      exp_d        = exp_q;
      err_d        = err_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
`ifdef OL_RX_ERR_SNAPSHOT_EN
      snap_exp_d   = snap_exp_q;
      snap_rx_d    = snap_rx_q;
      snap_v_d     = snap_v_q;
`endif
      if (!LIVE) begin
         state_d = ST_HUNT;
         align_d = '0;
         pass_d  = '0;
         tmo_d   = '0;
         los_d   = '0;
         err_d   = '0;
`ifdef OL_RX_ERR_SNAPSHOT_EN
         snap_exp_d = '0;
         snap_rx_d  = '0;
         snap_v_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_HUNT: begin
               if (aligned) begin
                  if (align_q + 16'd1 == LOCK_TC) begin
                     state_d = ST_LOCKED;
                     align_d = '0;
                  end else begin
                     align_d = align_q + 16'd1;
                  end
               end else if (rx_valid) begin
                  align_d = '0;
               end
            end
            ST_LOCKED: begin
               if (rx_valid) begin
                  if ((rx_datak == 2'b00) && (rx_data != ALIGN_WORD)) begin
                     state_d = ST_TEST;
                     exp_d   = rx_data + 16'd1;
                     pass_d  = '0;
                     tmo_d   = TMO_LOAD;
                  end else if ((rx_datak == 2'b01) || (rx_datak == 2'b10)) begin
                     state_d = ST_HUNT;
                     align_d = '0;
                  end
               end
            end
            ST_TEST: begin
               // timeout is a down-counter loaded on entry; terminal count 1 expires this cycle
               tmo_d = tmo_q - 16'd1;
               if (rx_valid) begin
                  exp_d = rx_data + 16'd1;
                  if (word_ok) begin
                     pass_d = pass_q + 16'd1;
                  end else begin
                     pass_d = '0;
                     if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`ifdef OL_RX_ERR_SNAPSHOT_EN
                     if (!snap_v_q) begin
                        snap_exp_d = exp_q;
                        snap_rx_d  = rx_data;
                        snap_v_d   = 1'b1;
                     end
`endif
                  end
               end
               if (rx_valid && word_ok && (pass_q + 16'd1 == PASS_TC)) begin
                  state_d = ST_DATA;
                  align_d = '0;
                  los_d   = '0;
               end else if (tmo_q == 16'd1) begin
                  state_d = ST_FAULT;
               end
            end
            ST_DATA: begin
               data_out_d   = rx_data;
               data_valid_d = rx_valid && (rx_datak == 2'b00);
               if (aligned) begin
                  if (align_q + 16'd1 == LOCK_TC) begin
                     state_d      = ST_LOCKED;
                     align_d      = '0;
                     data_valid_d = 1'b0;
                  end else begin
                     align_d = align_q + 16'd1;
                  end
               end else if (rx_valid) begin
                  align_d = '0;
               end
               if (!rx_valid) begin
                  if (los_q + 16'd1 == LOS_TC) begin
                     state_d      = ST_FAULT;
                     data_valid_d = 1'b0;
                  end
                  los_d = los_q + 16'd1;
               end else begin
                  los_d = '0;
               end
            end
            ST_FAULT: ;
            default: state_d = ST_HUNT;
         endcase
      end
      case (state_d)
         ST_TEST:  mode_d = 2'b01;
         ST_DATA:  mode_d = 2'b10;
         ST_FAULT: mode_d = 2'b11;
         default:  mode_d = 2'b00;
      endcase
      link_up_d = (state_d == ST_DATA);
      error_d   = (state_d != ST_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_HUNT;
         align_q      <= '0;
         pass_q       <= '0;
         tmo_q        <= '0;
         los_q        <= '0;
         exp_q        <= '0;
         err_q        <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         link_up_q    <= 1'b0;
         error_q      <= 1'b1;
         mode_q       <= 2'b00;
`ifdef OL_RX_ERR_SNAPSHOT_EN
         snap_exp_q   <= '0;
         snap_rx_q    <= '0;
         snap_v_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         align_q      <= align_d;
         pass_q       <= pass_d;
         tmo_q        <= tmo_d;
         los_q        <= los_d;
         exp_q        <= exp_d;
         err_q        <= err_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         link_up_q    <= link_up_d;
         error_q      <= error_d;
         mode_q       <= mode_d;
`ifdef OL_RX_ERR_SNAPSHOT_EN
         snap_exp_q   <= snap_exp_d;
         snap_rx_q    <= snap_rx_d;
         snap_v_q     <= snap_v_d;
`endif
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign link_up    = link_up_q;
   assign error      = error_q;
   assign mode       = mode_q;
   assign err_cnt    = err_q;
`ifdef OL_RX_ERR_SNAPSHOT_EN
   assign snap_expected = snap_exp_q;
   assign snap_received = snap_rx_q;
   assign snap_valid    = snap_v_q;
`endif

endmodule

// File: tb/tb_ol_rx_link_monitor.sv
// Scoreboard bench for ol_rx_link_monitor with reduced counts and a rule-level reference model.
module tb_ol_rx_link_monitor;
   localparam int AL = 8;
   localparam int PC = 20;
   localparam int TO = 60;
   localparam int LC = 5;
   localparam logic [15:0] AW = 16'h50BC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        live = 1'b0;
   logic [15:0] rx_data = '0;
   logic [1:0]  rx_datak = '0;
   logic        rx_valid = 1'b0;
   logic [15:0] data_out;
   logic        data_valid;
   logic        link_up;
   logic        error;
   logic [1:0]  mode;
   logic [15:0] err_cnt;

   always #5 clk = ~clk;

   ol_rx_link_monitor #(
      .ALIGN_WORD(AW), .ALIGN_LOCK_CNT(AL), .TEST_PASS_CNT(PC),
      .TEST_TIMEOUT(TO), .LOS_CNT(LC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .LIVE(live), .rx_data(rx_data), .rx_datak(rx_datak),
      .rx_valid(rx_valid), .data_out(data_out), .data_valid(data_valid),
      .link_up(link_up), .error(error), .mode(mode), .err_cnt(err_cnt)
   );

   typedef struct {int mode; int link; int err; int ecnt; int dv; int dout;} exp_t;
   exp_t sbq[$];
   exp_t mon_e;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // reference model: phase names are link phases, counters are plain integers
   localparam int PH_SEARCH = 0, PH_ALIGNED = 1, PH_CHECK = 2, PH_RUN = 3, PH_DEAD = 4;
   int ph, m_al, m_pass, m_age, m_los, m_exp, m_err, m_dout, m_dv;

   task automatic m_reset();
      ph = PH_SEARCH; m_al = 0; m_pass = 0; m_age = 0; m_los = 0;
      m_exp = 0; m_err = 0; m_dout = 0; m_dv = 0;
   endtask

   task automatic m_step(input bit lv, input bit v, input bit [1:0] k, input bit [15:0] d);
      bit al_w;
      al_w = v && (k == 2'b11) && (d == AW);
      m_dv = 0;
      if (!lv) begin
         ph = PH_SEARCH; m_al = 0; m_pass = 0; m_age = 0; m_los = 0; m_err = 0;
         return;
      end
      if (ph == PH_SEARCH) begin
         if (al_w) begin
            m_al++;
            if (m_al == AL) begin ph = PH_ALIGNED; m_al = 0; end
         end else if (v) m_al = 0;
      end else if (ph == PH_ALIGNED) begin
         if (v && k == 2'b00 && d != AW) begin
            ph = PH_CHECK; m_exp = (int'(d) + 1) % 65536; m_pass = 0; m_age = 0;
         end else if (v && (k == 2'b01 || k == 2'b10)) begin
            ph = PH_SEARCH; m_al = 0;
         end
      end else if (ph == PH_CHECK) begin
         m_age++;
         if (v) begin
            if (k == 2'b00 && int'(d) == m_exp) m_pass++;
            else begin
               m_pass = 0;
               if (m_err < 65535) m_err++;
            end
            m_exp = (int'(d) + 1) % 65536;
         end
         if (m_pass == PC) begin ph = PH_RUN; m_al = 0; m_los = 0; end
         else if (m_age == TO) ph = PH_DEAD;
      end else if (ph == PH_RUN) begin
         m_dout = int'(d);
         m_dv = (v && k == 2'b00) ? 1 : 0;
         if (al_w) m_al++; else if (v) m_al = 0;
         if (!v) m_los++; else m_los = 0;
         if (m_al == AL) begin ph = PH_ALIGNED; m_al = 0; m_dv = 0; end
         if (m_los == LC) begin ph = PH_DEAD; m_dv = 0; end
      end
   endtask

   function automatic exp_t m_out();
      exp_t e;
      e.mode = (ph == PH_CHECK) ? 1 : (ph == PH_RUN) ? 2 : (ph == PH_DEAD) ? 3 : 0;
      e.link = (ph == PH_RUN) ? 1 : 0;
      e.err  = (ph == PH_RUN) ? 0 : 1;
      e.ecnt = m_err;
      e.dv   = m_dv;
      e.dout = m_dout;
      return e;
   endfunction

   task automatic drive(input bit lv, input bit v, input bit [1:0] k, input bit [15:0] d);
      @(negedge clk);
      live = lv; rx_valid = v; rx_datak = k; rx_data = d;
      m_step(lv, v, k, d);
      sbq.push_back(m_out());
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n && sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("mode", int'(mode), mon_e.mode);
         chk("link_up", int'(link_up), mon_e.link);
         chk("error", int'(error), mon_e.err);
         chk("err_cnt", int'(err_cnt), mon_e.ecnt);
         chk("data_valid", int'(data_valid), mon_e.dv);
         chk("data_out", int'(data_out), mon_e.dout);
      end
   end

   task automatic settle();
      @(posedge clk); #2;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_data_out"}, int'(data_out), 0);
      chk({tag, "_data_valid"}, int'(data_valid), 0);
      chk({tag, "_link_up"}, int'(link_up), 0);
      chk({tag, "_error"}, int'(error), 1);
      chk({tag, "_mode"}, int'(mode), 0);
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
   endtask

   task automatic align_run(input int n);
      repeat (n) drive(1, 1, 2'b11, AW);
   endtask

   task automatic to_test(input logic [15:0] start);
      align_run(AL);
      repeat (10) drive(1, 1, 2'b00, AW);
      drive(1, 1, 2'b00, start);
   endtask

   task automatic count_run(input logic [15:0] start, input int n);
      logic [15:0] c;
      c = start;
      repeat (n) begin drive(1, 1, 2'b00, c); c = c + 16'd1; end
   endtask

   task automatic live_off();
      drive(0, 0, 2'b00, 16'h0000);
   endtask

   initial begin
      int fault_at;
      logic [15:0] cval;
      int r;
      m_reset();
      #12;
      check_reset_vals("rst0");
      @(negedge clk); rst_n = 1'b1;

      // nominal bring-up to DATA
      to_test(16'h0000);
      settle();
      chk("enter_test_mode", int'(mode), 1);
      count_run(16'h0001, PC);
      settle();
      chk("s1_mode", int'(mode), 2);
      chk("s1_link", int'(link_up), 1);

      // one corrupted word, stream continues from the corrupted value
      live_off();
      to_test(16'h0000);
      count_run(16'h0001, 4);
      drive(1, 1, 2'b00, 16'h1234);
      count_run(16'h1235, PC - 1);
      settle();
      chk("s2_not_yet", int'(mode), 1);
      count_run(16'h1235 + 16'(PC - 1), 1);
      settle();
      chk("s2_mode", int'(mode), 2);
      chk("s2_errcnt", int'(err_cnt), 1);

      // counter wrap FFFF->0000 is a match
      live_off();
      to_test(16'hFFF0);
      count_run(16'hFFF1, PC);
      settle();
      chk("s3_mode", int'(mode), 2);
      chk("s3_errcnt", int'(err_cnt), 0);

      // TEST timeout
      live_off();
      to_test(16'h0000);
      fault_at = 0;
      for (int i = 1; i <= TO + 3; i++) begin
         if (i == 1) drive(1, 1, 2'b00, 16'h7777);
         else drive(1, 0, 2'b00, 16'h0000);
         settle();
         if (mode == 2'b11 && fault_at == 0) fault_at = i;
      end
      chk("s4_fault_cycle", fault_at, TO);
      chk("s4_error", int'(error), 1);
      chk("s4_errcnt", int'(err_cnt), 1);
      live_off();
      settle();
      chk("s4_live_mode", int'(mode), 0);
      chk("s4_live_errcnt", int'(err_cnt), 0);

      // DATA payload then loss of signal
      to_test(16'h0000);
      count_run(16'h0001, PC);
      drive(1, 1, 2'b00, 16'hA5A5);
      settle();
      chk("s5_dout", int'(data_out), 16'hA5A5);
      chk("s5_dv", int'(data_valid), 1);
      repeat (6) drive(1, $urandom_range(0, 1), 2'($urandom_range(0, 1)), 16'($urandom));
      drive(1, 1, 2'b00, 16'h1111);
      for (int i = 1; i <= LC; i++) begin
         drive(1, 0, 2'b00, 16'h0000);
         settle();
         if (i < LC) chk("s5_still_data", int'(mode), 2);
         else begin
            chk("s5_los_mode", int'(mode), 3);
            chk("s5_los_link", int'(link_up), 0);
         end
      end

      // DATA back to LOCKED on re-alignment, then async reset mid-stream
      live_off();
      to_test(16'h0000);
      drive(1, 1, 2'b00, 16'h4444);
      count_run(16'h4445, PC);
      align_run(AL);
      settle();
      chk("s6_mode", int'(mode), 0);
      chk("s6_link", int'(link_up), 0);
      chk("s6_error", int'(error), 1);
      align_run(3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      sbq.delete();
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // randomized mix
      for (int round = 0; round < 5; round++) begin
         live_off();
         align_run(AL);
         drive(1, 1, 2'b00, AW);
         cval = 16'($urandom);
         for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin drive(1, 1, 2'b00, cval); cval = cval + 16'd1; end
            else if (r < 78) drive(1, 0, 2'($urandom), 16'($urandom));
            else if (r < 86) drive(1, 1, 2'b11, AW);
            else if (r < 89) drive(1, 1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 16'($urandom));
            else if (r < 98) begin cval = 16'($urandom); drive(1, 1, 2'b00, cval); cval = cval + 16'd1; end
            else if (r < 99) align_run(AL);
            else live_off();
         end
      end

      settle();
      chk("sb_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
